draw_rect_multi: RTL

- Parametrised successor to the single-rectangle overlay stage in the VGA pipeline.
- Sits between draw_bg and the output in the vga_if chain.
- Overlays NUM_RECT independently configurable rectangles with fixed priority: lowest index wins.
- Geometry and colour are written at run time through a valid/ready config port. Writes are buffered in shadow registers and committed only at the start of vertical blank, so no frame ever shows a half-updated rectangle.

---
 rtl/draw_rect_multi_if.sv | 17 +
 rtl/draw_rect_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_multi_if.sv
// VGA pixel-stream bundle passed between stages of the video pipeline.
// The master drives the stream; the slave consumes it.
interface vga_if #(
    parameter int CNT_W = 11,
    parameter int RGB_W = 12
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_multi.sv
// draw_rect_multi: overlays NUM_RECT run-time configurable rectangles on the
// VGA stream with a fixed 2-cycle latency; lowest index has priority.
// Config writes land in shadow registers and are committed to the active set
// in the single COMMIT cycle that follows the start of vertical blank.
// Optional build macro DRAW_RECT_MULTI_BORDER_EN adds a per-rectangle
// 4-bit border width (cfg_border); 0 keeps the rectangle filled.
module draw_rect_multi #(
    parameter  int NUM_RECT = 4,
    parameter  int CNT_W    = 11,
    parameter  int RGB_W    = 12,
    localparam int IDX_W    = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    vga_if.slave             vga_in,
    vga_if.master            vga_out,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_xpos,
    input  logic [CNT_W-1:0] cfg_ypos,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_height,
    input  logic [RGB_W-1:0] cfg_rgb
`ifdef DRAW_RECT_MULTI_BORDER_EN
    ,
    input  logic [3:0]       cfg_border
`endif
);

    typedef enum logic {IDLE, COMMIT} state_t;

    typedef struct packed {
        logic             en;
        logic [CNT_W-1:0] xpos;
        logic [CNT_W-1:0] ypos;
        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] height;
        logic [RGB_W-1:0] rgb;
`ifdef DRAW_RECT_MULTI_BORDER_EN
        logic [3:0]       border;
`endif
    } rect_t;

    state_t              state;
    rect_t               shadow [NUM_RECT];
    rect_t               active [NUM_RECT];
    logic [NUM_RECT-1:0] dirty;
    rect_t               cfg_entry;
    logic                cfg_fire;
    logic                vblnk_rise;

    logic                hit_any;
    logic [RGB_W-1:0]    hit_rgb;

    logic [CNT_W-1:0]    hcount_p1, vcount_p1;
    logic                hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;
    logic [RGB_W-1:0]    rgb_p1;
    logic                hit_p1;
    logic [RGB_W-1:0]    hit_rgb_p1;

    logic [CNT_W-1:0]    hcount_p2, vcount_p2;
    logic                hsync_p2, vsync_p2, hblnk_p2, vblnk_p2;
    logic [RGB_W-1:0]    rgb_p2;

    // Offsets are only meaningful once the >= test holds, so they never wrap
    // into a false hit; zero width or height can never satisfy dx < width.
    function automatic logic rect_hit(input rect_t r,
                                      input logic [CNT_W-1:0] h,
                                      input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] dx;
        logic [CNT_W-1:0] dy;
        logic             hit;
`ifdef DRAW_RECT_MULTI_BORDER_EN
        logic [CNT_W-1:0] b;
        logic [CNT_W-1:0] rx;
        logic [CNT_W-1:0] by;
`endif
        dx  = h - r.xpos;
        dy  = v - r.ypos;
        hit = r.en && (h >= r.xpos) && (dx < r.width)
                   && (v >= r.ypos) && (dy < r.height);
`ifdef DRAW_RECT_MULTI_BORDER_EN
        b  = CNT_W'(r.border);
        rx = r.width - 1'b1 - dx;
        by = r.height - 1'b1 - dy;
        if (r.border != 4'd0)
            hit = hit && ((dx < b) || (rx < b) || (dy < b) || (by < b));
`endif
        return hit;
    endfunction

    assign cfg_fire   = cfg_valid && cfg_ready;
    assign vblnk_rise = !vblnk_p1 && vga_in.vblnk;

    // Pack the config port into one entry image
    always_comb begin
        cfg_entry        = '0;
        cfg_entry.en     = cfg_en;
        cfg_entry.xpos   = cfg_xpos;
        cfg_entry.ypos   = cfg_ypos;
        cfg_entry.width  = cfg_width;
        cfg_entry.height = cfg_height;
        cfg_entry.rgb    = cfg_rgb;
`ifdef DRAW_RECT_MULTI_BORDER_EN
        cfg_entry.border = cfg_border;
`endif
    end

    // Commit FSM: one COMMIT cycle per vblank entry, config port closed during it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vblnk_rise) begin
                        state     <= COMMIT;
                        cfg_ready <= 1'b0;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Shadow writes, dirty tracking and shadow-to-active copy on commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dirty <= '0;
            for (int i = 0; i < NUM_RECT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else if (state == COMMIT) begin
            for (int i = 0; i < NUM_RECT; i++)
                if (dirty[i])
                    active[i] <= shadow[i];
            dirty <= '0;
        end else if (cfg_fire) begin
            // Out-of-range indices match no entry and are dropped silently
            for (int i = 0; i < NUM_RECT; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    shadow[i] <= cfg_entry;
                    dirty[i]  <= 1'b1;
                end
            end
        end
    end

    // Priority resolve: scanning downwards leaves the lowest hit index last
    always_comb begin
        hit_any = 1'b0;
        hit_rgb = '0;
        for (int i = NUM_RECT - 1; i >= 0; i--) begin
            if (rect_hit(active[i], vga_in.hcount, vga_in.vcount)) begin
                hit_any = 1'b1;
                hit_rgb = active[i].rgb;
            end
        end
    end

    // ---- stage 1: register input stream and winning rectangle ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_p1  <= '0;
            vcount_p1  <= '0;
            hsync_p1   <= 1'b0;
            vsync_p1   <= 1'b0;
            hblnk_p1   <= 1'b0;
            vblnk_p1   <= 1'b0;
            rgb_p1     <= '0;
            hit_p1     <= 1'b0;
            hit_rgb_p1 <= '0;
        end else begin
            hcount_p1  <= vga_in.hcount;
            vcount_p1  <= vga_in.vcount;
            hsync_p1   <= vga_in.hsync;
            vsync_p1   <= vga_in.vsync;
            hblnk_p1   <= vga_in.hblnk;
            vblnk_p1   <= vga_in.vblnk;
            rgb_p1     <= vga_in.rgb;
            hit_p1     <= hit_any;
            hit_rgb_p1 <= hit_rgb;
        end
    end

    // ---- stage 2: colour mux, blanking always passes the source rgb ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_p2 <= '0;
            vcount_p2 <= '0;
            hsync_p2  <= 1'b0;
            vsync_p2  <= 1'b0;
            hblnk_p2  <= 1'b0;
            vblnk_p2  <= 1'b0;
            rgb_p2    <= '0;
        end else begin
            hcount_p2 <= hcount_p1;
            vcount_p2 <= vcount_p1;
            hsync_p2  <= hsync_p1;
            vsync_p2  <= vsync_p1;
            hblnk_p2  <= hblnk_p1;
            vblnk_p2  <= vblnk_p1;
            rgb_p2    <= (hit_p1 && !(hblnk_p1 || vblnk_p1)) ? hit_rgb_p1 : rgb_p1;
        end
    end

    assign vga_out.hcount = hcount_p2;
    assign vga_out.vcount = vcount_p2;
    assign vga_out.hsync  = hsync_p2;
    assign vga_out.vsync  = vsync_p2;
    assign vga_out.hblnk  = hblnk_p2;
    assign vga_out.vblnk  = vblnk_p2;
    assign vga_out.rgb    = rgb_p2;

endmodule
